stack_scan_ctrl: RTL and testbench
==================================

STACK_SCAN_CTRL -- requirements
Module: stack_scan_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 20: response-wait window in clk cycles per command (range 2..31).
REQ-002 Parameter MAX_ID, default 15: highest chip ID scanned (range 2..15).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  scan request pulse; sampled only in IDLE and DONE.
REQ-006 sort_finish  input  1  chip-ID sort complete on this layer.
REQ-007 rx_data  input  32  frame from vertical bus.
REQ-008 tx_valid  output  1  one-cycle command strobe.
REQ-009 tx_data  output  32  command frame; 0 when tx_valid=0.
REQ-010 busy  output  1  high in every state except IDLE and DONE.
REQ-011 done  output  1  high while in DONE.
REQ-012 chip_count  output  4  number of chips found, including the first layer.
REQ-013 fail  output  1  ID mismatch detected.
REQ-014 fail_id  output  4  target ID at which the mismatch occurred.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_SORT, SEND, WAIT_RSP, NEXT and DONE, all registered.
REQ-016 IDLE: start=1 -> WAIT_SORT; set target=2, retry=0, chip_count=1, fail=0, fail_id=0.
REQ-017 WAIT_SORT: sort_finish=1 -> SEND; otherwise hold.
REQ-018 SEND lasts exactly one cycle.
REQ-018a In SEND: tx_valid=1, tx_data={4'hC, 4'h0, 4'h1, target, 16'hBEEF}; clear timer to 0; next state WAIT_RSP.
REQ-019 WAIT_RSP: timer increments each cycle from 0 to TIMEOUT-1.
REQ-019a A response is valid when rx_data[31:28]=4'h5 and rx_data[15:0]=16'hBEEF.
REQ-020 Valid response with rx_data[19:16]=target -> chip_count<=target; next state NEXT.
REQ-021 Valid response with rx_data[19:16]!=target -> fail<=1, fail_id<=target; next state DONE.
REQ-022 Invalid frames SHALL be ignored.
REQ-023 No valid response by timer=TIMEOUT-1 -> retry handling per REQ-033/034.
REQ-023a A response in the timer=TIMEOUT-1 cycle SHALL win over timeout.
REQ-024 NEXT: target=MAX_ID -> DONE; otherwise target<=target+1, retry<=0, next state SEND.
REQ-024a The target counter SHALL never wrap.
REQ-025 DONE: done=1; chip_count, fail and fail_id held.
REQ-025a start=1 in DONE -> reinitialise as in REQ-016 and go to WAIT_SORT.
REQ-026 start SHALL be ignored while busy=1.
REQ-026a sort_finish deassertion after WAIT_SORT SHALL be ignored.
REQ-027 A timeout from the first target with no prior responses SHALL end with chip_count=1 and fail=0.

Reset
REQ-028 rst=1 SHALL force IDLE on the next edge from any state, including mid-WAIT_RSP.
REQ-029 Reset values: tx_valid=0, tx_data=0, busy=0, done=0, chip_count=1, fail=0, fail_id=0.
REQ-029a Reset values (internal): target=2, retry=0, timer=0.
REQ-030 rst SHALL take priority over start and every other input.

Configuration
REQ-031 Macro SCAN_RETRY_EN SHALL select the retry feature.
REQ-032 A retry counter SHALL exist only when SCAN_RETRY_EN is defined.
REQ-033 With SCAN_RETRY_EN defined, on timeout: if retry<2, retry++ and return to SEND (up to 3 commands per target); if retry=2, go to DONE.
REQ-034 With SCAN_RETRY_EN undefined, timeout SHALL go to DONE directly (1 command per target).

Verification
REQ-035 Reset scenario: assert rst in any state -> next cycle IDLE, tx_valid=0, done=0, chip_count=1, fail=0.
REQ-036 Three-chip stack (SCAN_RETRY_EN on): start, then sort_finish; reply 32'h5002BEEF and 32'h5003BEEF 5 cycles after each tx; silent for ID 4 -> 3 tx_valid pulses for ID 4, then done=1, chip_count=3, fail=0.
REQ-037 Timeout boundary (TIMEOUT=20): reply arriving at timer=19 is accepted (chip_count=2).
REQ-037a Timeout boundary (TIMEOUT=20): the same reply at the cycle after timer=19 is ignored and a retry SEND follows.
REQ-038 ID mismatch: target 2, rx 32'h5003BEEF -> fail=1, fail_id=2, done=1, chip_count=1.
REQ-039 Mid-scan reset: rst during WAIT_RSP for target 3 -> IDLE, busy=0.
REQ-039a Mid-scan restart: start, then sort_finish -> next tx_data=32'hC012BEEF.
REQ-040 Macro off: silent target 2 -> exactly one tx_valid pulse, then done=1, chip_count=1 after TIMEOUT cycles.

Source files
------------

// File: rtl/stack_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// stack_scan_ctrl_if
//   Groups the scan controller's handshake and vertical-bus signals.
//
//   start        scan request pulse (toward controller)
//   sort_finish  chip-ID sort complete on this layer (toward controller)
//   rx_data      32-bit frame received from the vertical bus (toward controller)
//   tx_valid     one-cycle command strobe (from controller)
//   tx_data      32-bit command frame, zero when tx_valid is low (from controller)
//
//   master : the scan controller
//   slave  : the environment / bus side that drives requests and responses
// ----------------------------------------------------------------------------
interface stack_scan_ctrl_if;
    logic        start;
    logic        sort_finish;
    logic [31:0] rx_data;
    logic        tx_valid;
    logic [31:0] tx_data;

    modport master (
        input  start,
        input  sort_finish,
        input  rx_data,
        output tx_valid,
        output tx_data
    );

    modport slave (
        output start,
        output sort_finish,
        output rx_data,
        input  tx_valid,
        input  tx_data
    );
endinterface

// File: rtl/stack_scan_ctrl.sv
// ----------------------------------------------------------------------------
// stack_scan_ctrl
//   Scans a chip stack over the vertical bus.  After the local chip-ID sort
//   completes it sends one command per target ID (2..MAX_ID) and waits up to
//   TIMEOUT cycles for a matching reply.  The scan stops at the first silent
//   target, at an ID mismatch, or after MAX_ID has answered.
//
//   Optional feature (macro SCAN_RETRY_EN): a silent target is re-commanded
//   up to two more times before the scan gives up.  Without the macro a
//   single timeout ends the scan.
//
// Parameters
//   TIMEOUT     response-wait window per command in clk cycles (2..31)
//   MAX_ID      highest chip ID scanned (2..15)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   bus         stack_scan_ctrl_if.master (start, sort_finish, rx_data in;
//               tx_valid, tx_data out)
//   busy        high in every state except IDLE and DONE
//   done        high while in DONE
//   chip_count  number of chips found, including this layer
//   fail        an ID mismatch was detected
//   fail_id     target ID at which the mismatch occurred
// ----------------------------------------------------------------------------
module stack_scan_ctrl #(
    parameter int TIMEOUT = 20,
    parameter int MAX_ID  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_scan_ctrl_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           chip_count,
    output logic                 fail,
    output logic [3:0]           fail_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SORT,
        S_SEND,
        S_WAIT_RSP,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [4:0] TIMER_LAST = 5'(TIMEOUT - 1);
    localparam logic [3:0] ID_FIRST   = 4'd2;
    localparam logic [3:0] ID_LAST    = 4'(MAX_ID);

    state_t     state_q, state_d;
    logic [3:0] target_q, target_d;
    logic [4:0] timer_q, timer_d;
    logic [3:0] chip_count_q, chip_count_d;
    logic       fail_q, fail_d;
    logic [3:0] fail_id_q, fail_id_d;
`ifdef SCAN_RETRY_EN
    logic [1:0] retry_q, retry_d;
`endif

    logic rsp_valid;
    logic rsp_match;
    logic timed_out;
    logic unused_rx_bits;

    // A reply frame carries header nibble 5 and the BEEF tag; anything else
    // on the bus is traffic for someone else.
    assign rsp_valid = (bus.rx_data[31:28] == 4'h5) && (bus.rx_data[15:0] == 16'hBEEF);
    assign rsp_match = (bus.rx_data[19:16] == target_q);
    assign timed_out = (timer_q == TIMER_LAST);

    // Reserved reply bits carry nothing for the controller.
    assign unused_rx_bits = ^bus.rx_data[27:20];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            target_q     <= ID_FIRST;
            timer_q      <= '0;
            chip_count_q <= 4'd1;
            fail_q       <= 1'b0;
            fail_id_q    <= '0;
`ifdef SCAN_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            timer_q      <= timer_d;
            chip_count_q <= chip_count_d;
            fail_q       <= fail_d;
            fail_id_q    <= fail_id_d;
`ifdef SCAN_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        timer_d      = timer_q;
        chip_count_d = chip_count_q;
        fail_d       = fail_q;
        fail_id_d    = fail_id_q;
`ifdef SCAN_RETRY_EN
        retry_d      = retry_q;
`endif
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d      = S_WAIT_SORT;
                    target_d     = ID_FIRST;
                    chip_count_d = 4'd1;
                    fail_d       = 1'b0;
                    fail_id_d    = '0;
`ifdef SCAN_RETRY_EN
                    retry_d      = '0;
`endif
                end
            end

            S_WAIT_SORT: begin
                if (bus.sort_finish) begin
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = {4'hC, 4'h0, 4'h1, target_q, 16'hBEEF};
                timer_d      = '0;
                state_d      = S_WAIT_RSP;
            end

            S_WAIT_RSP: begin
                // A reply in the last window cycle is checked before the
                // timeout, so it still counts.
                if (rsp_valid) begin
                    if (rsp_match) begin
                        chip_count_d = target_q;
                        state_d      = S_NEXT;
                    end else begin
                        fail_d    = 1'b1;
                        fail_id_d = target_q;
                        state_d   = S_DONE;
                    end
                end else if (timed_out) begin
`ifdef SCAN_RETRY_EN
                    if (retry_q < 2'd2) begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end else begin
                    timer_d = timer_q + 5'd1;
                end
            end

            S_NEXT: begin
                // Stop at MAX_ID rather than incrementing so target never wraps.
                if (target_q == ID_LAST) begin
                    state_d = S_DONE;
                end else begin
                    target_d = target_q + 4'd1;
`ifdef SCAN_RETRY_EN
                    retry_d  = '0;
`endif
                    state_d  = S_SEND;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign chip_count = chip_count_q;
    assign fail       = fail_q;
    assign fail_id    = fail_id_q;

endmodule

// File: tb/tb_stack_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stack_scan_ctrl
//   Directed bench for stack_scan_ctrl with default TIMEOUT=20, MAX_ID=15.
//   Inputs change 1 time unit after each rising edge and outputs are sampled
//   at the same point, so each tick() observes the state entered on that edge.
//   Expectations for a silent target follow SCAN_RETRY_EN when it is defined
//   for the build (3 commands per target) and 1 command otherwise.
// ----------------------------------------------------------------------------
module tb_stack_scan_ctrl;

    localparam int TIMEOUT = 20;
    localparam int MAX_ID  = 15;
`ifdef SCAN_RETRY_EN
    localparam int CMDS_PER_TARGET = 3;
`else
    localparam int CMDS_PER_TARGET = 1;
`endif
    // One SEND cycle plus a full TIMEOUT-cycle wait per command.
    localparam int SILENT_TICKS = CMDS_PER_TARGET * (TIMEOUT + 1);
    localparam int WAIT_BUDGET  = 500;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic       done;
    logic [3:0] chip_count;
    logic       fail;
    logic [3:0] fail_id;

    int checks   = 0;
    int failures = 0;

    stack_scan_ctrl_if bus ();

    stack_scan_ctrl #(
        .TIMEOUT (TIMEOUT),
        .MAX_ID  (MAX_ID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .chip_count (chip_count),
        .fail       (fail),
        .fail_id    (fail_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one frame for exactly one sampling edge.
    task automatic pulse_rx(input logic [31:0] frame);
        bus.rx_data = frame;
        tick();
        bus.rx_data = '0;
    endtask

    // start pulse then sort_finish pulse; returns sampled in the first SEND.
    task automatic start_scan();
        bus.start = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.sort_finish = 1'b1;
        tick();
        bus.sort_finish = 1'b0;
    endtask

    // Called while sampling a SEND cycle; runs silently until DONE or budget.
    task automatic wait_silent(output int pulses, output int ticks);
        pulses = 1;
        ticks  = 0;
        while (!done && ticks < WAIT_BUDGET) begin
            tick();
            ticks++;
            if (bus.tx_valid) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int ticks;

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.sort_finish = 1'b0;
        bus.rx_data     = '0;
        tick_n(2);

        // Reset state
        check("rst_busy",       busy,         32'd0);
        check("rst_done",       done,         32'd0);
        check("rst_tx_valid",   bus.tx_valid, 32'd0);
        check("rst_tx_data",    bus.tx_data,  32'd0);
        check("rst_chip_count", chip_count,   32'd1);
        check("rst_fail",       fail,         32'd0);
        check("rst_fail_id",    fail_id,      32'd0);

        // rst beats start
        bus.start = 1'b1;
        tick();
        check("rst_over_start", busy, 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        check("idle_hold", busy, 32'd0);

        // Three-chip stack: IDs 2 and 3 answer, ID 4 is silent
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("wait_sort_busy", busy, 32'd1);
        tick_n(2);
        check("wait_sort_hold", {bus.tx_valid, busy}, 32'b01);
        bus.sort_finish = 1'b1;
        tick();
        bus.sort_finish = 1'b0;
        check("t2_tx_valid", bus.tx_valid, 32'd1);
        check("t2_tx_data",  bus.tx_data,  32'hC012BEEF);
        tick();
        check("t2_strobe_one_cycle", bus.tx_valid, 32'd0);
        tick_n(4);                       // timer = 4
        pulse_rx(32'h5002BEEF);
        check("t2_chip_count", chip_count, 32'd2);
        tick();
        check("t3_tx_data", bus.tx_data, 32'hC013BEEF);
        tick_n(5);
        pulse_rx(32'h5003BEEF);
        tick();
        check("t4_tx_data", bus.tx_data, 32'hC014BEEF);
        wait_silent(pulses, ticks);
        check("t4_pulses",     pulses,     CMDS_PER_TARGET);
        check("t4_ticks",      ticks,      SILENT_TICKS);
        check("t4_done",       done,       32'd1);
        check("t4_busy",       busy,       32'd0);
        check("t4_chip_count", chip_count, 32'd3);
        check("t4_fail",       fail,       32'd0);
        tick_n(2);
        check("done_hold_count", chip_count, 32'd3);

        // Restart from DONE; start stays high while busy and must be ignored.
        // The reply lands in the timer=TIMEOUT-1 cycle.
        bus.start = 1'b1;
        tick();
        check("restart_count_init", chip_count, 32'd1);
        check("restart_done_low",   done,       32'd0);
        bus.sort_finish = 1'b1;
        tick();
        bus.sort_finish = 1'b0;
        check("restart_tx_data", bus.tx_data, 32'hC012BEEF);
        tick_n(TIMEOUT);                 // timer = TIMEOUT-1
        pulse_rx(32'h5002BEEF);
        bus.start = 1'b0;
        check("boundary_accept", chip_count, 32'd2);
        tick();
        check("start_ignored_busy", bus.tx_data, 32'hC013BEEF);

        // Reset in the middle of WAIT_RSP for target 3
        tick_n(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midscan_rst_busy",  busy,         32'd0);
        check("midscan_rst_tx",    bus.tx_valid, 32'd0);
        check("midscan_rst_count", chip_count,   32'd1);
        check("midscan_rst_done",  done,         32'd0);
        start_scan();
        check("midscan_restart_tx", bus.tx_data, 32'hC012BEEF);

        // Reply one cycle after the window closed is ignored
        tick_n(TIMEOUT + 1);
        check("late_retry_send", bus.tx_valid, (CMDS_PER_TARGET > 1) ? 32'd1 : 32'd0);
        check("late_done",       done,         (CMDS_PER_TARGET > 1) ? 32'd0 : 32'd1);
        pulse_rx(32'h5002BEEF);
        check("late_reply_ignored", chip_count, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Invalid frames ignored, then an ID mismatch
        start_scan();
        tick();                          // timer = 0
        pulse_rx(32'h5002BEE0);
        pulse_rx(32'h6002BEEF);
        check("invalid_ignored_busy", busy, 32'd1);
        check("invalid_ignored_done", done, 32'd0);
        pulse_rx(32'h5003BEEF);
        check("mismatch_fail",       fail,       32'd1);
        check("mismatch_fail_id",    fail_id,    32'd2);
        check("mismatch_done",       done,       32'd1);
        check("mismatch_chip_count", chip_count, 32'd1);

        // Silent first target from DONE: no chips beyond this layer
        start_scan();
        check("silent_fail_cleared", fail,         32'd0);
        check("silent_tx_valid",     bus.tx_valid, 32'd1);
        wait_silent(pulses, ticks);
        check("silent_pulses",     pulses,     CMDS_PER_TARGET);
        check("silent_ticks",      ticks,      SILENT_TICKS);
        check("silent_done",       done,       32'd1);
        check("silent_chip_count", chip_count, 32'd1);
        check("silent_fail",       fail,       32'd0);

        // Full stack up to MAX_ID: scan stops there without wrapping
        start_scan();
        for (int id = 2; id <= MAX_ID; id++) begin
            check($sformatf("full_tx_%0d", id), bus.tx_data,
                  {4'hC, 4'h0, 4'h1, 4'(id), 16'hBEEF});
            tick();
            pulse_rx({4'h5, 8'h00, 4'(id), 16'hBEEF});
            tick();
        end
        check("full_done",       done,       32'd1);
        check("full_chip_count", chip_count, 32'd15);
        check("full_fail",       fail,       32'd0);
        tick_n(3);
        check("full_no_wrap_tx", bus.tx_valid, 32'd0);
        check("full_done_hold",  done,         32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
